cdc_glitch_filter: RTL and testbench
====================================

# cdc_glitch_filter

Qualifies the output of the two-flop synchronizer in the destination clock domain. The block accepts a level change only after the synchronized input has held the new value for a programmable number of consecutive cycles. It then produces a clean level, single-cycle rise/fall pulses, and a saturating count of accepted edges. It sits directly downstream of the synchronizer; the top level chains the two, and this block does not instantiate the synchronizer.

## Interface
- STABLE_CYCLES, 4: consecutive equal samples required to accept a change; legal range 1..255.
- CNT_WIDTH, 8: width of the accepted-edge counter; minimum 2.
- clk  input  1  destination-domain clock; all logic on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- i_sig_sync  input  1  synchronizer output; already in the clk domain.
- i_clr_cnt  input  1  synchronous clear of the edge counter.
- o_level  output  1  filtered level.
- o_rise  output  1  one-cycle pulse on an accepted 0->1 change.
- o_fall  output  1  one-cycle pulse on an accepted 1->0 change.
- o_edge_cnt  output  CNT_WIDTH  count of accepted edges (rise plus fall), saturating.
- o_cnt_sat  output  1  high while o_edge_cnt equals its all-ones value.

## Operation
- The FSM has four states:
  - S_LOW: stable low.
  - S_LOW_CHK: low, qualifying a high.
  - S_HIGH: stable high.
  - S_HIGH_CHK: high, qualifying a low.
- The qualification counter qcnt is $clog2(STABLE_CYCLES+1) bits wide. It is zero in S_LOW and S_HIGH.
- S_LOW:
  - i_sig_sync=1 and STABLE_CYCLES==1: go to S_HIGH and assert o_rise.
  - i_sig_sync=1 otherwise: go to S_LOW_CHK with qcnt=1.
- S_LOW_CHK:
  - i_sig_sync=0: return to S_LOW and clear qcnt (glitch rejected; no pulse, no count).
  - i_sig_sync=1 and qcnt==STABLE_CYCLES-1: go to S_HIGH and assert o_rise.
  - i_sig_sync=1 otherwise: increment qcnt.
- S_HIGH and S_HIGH_CHK mirror S_LOW and S_LOW_CHK with the polarity inverted; acceptance asserts o_fall.
- o_level is 1 in S_HIGH and S_HIGH_CHK, and 0 otherwise.
- o_rise and o_fall are never high in the same cycle. Each is high for exactly one cycle per accepted edge.
- Edge counter:
  - Increments by 1 on each o_rise or o_fall cycle.
  - Holds at 2^CNT_WIDTH-1; it never wraps.
  - o_cnt_sat is combinational from o_edge_cnt.
- i_clr_cnt:
  - Alone: the counter becomes 0 on the next edge.
  - Same cycle as an edge acceptance: the counter becomes 1 (the clear applies first, then the edge is counted).
  - The clear also releases saturation.
- i_clr_cnt does not affect the FSM, qcnt, or o_level.

## Timing
- Reset (rst_n=0 at a clock edge):
  - Outputs: o_level=0, o_rise=0, o_fall=0, o_edge_cnt=0, o_cnt_sat=0.
  - Internal: state=S_LOW, qcnt=0.
- Reset mid-qualification discards the partial count.
- If the input is high when reset releases, the high is qualified from scratch: o_rise appears STABLE_CYCLES cycles after the first sampled edge.
- Latency: if i_sig_sync is sampled 1 at edges t..t+N-1 (N=STABLE_CYCLES), o_level and o_rise become 1 right after edge t+N-1.
  - For N=1, this is one register of delay.
- End-to-end latency from an asynchronous pin to o_level is the synchronizer depth plus STABLE_CYCLES cycles.
- All outputs are registered, except o_cnt_sat, which is combinational from a register.
- A pulse train whose high and low phases each last at least N cycles is tracked exactly.
- Any shorter phase is suppressed entirely, including its return edge.

## Structure
- Shared package cdc_pkg holds:
  - typedef enum logic [1:0] {S_LOW, S_LOW_CHK, S_HIGH, S_HIGH_CHK} glitch_state_t;
  - localparam MAX_STABLE_CYCLES = 255.
- An elaboration-time check rejects STABLE_CYCLES < 1, STABLE_CYCLES > MAX_STABLE_CYCLES, and CNT_WIDTH < 2.
- One sub-module: sat_counter. It takes parameter WIDTH and ports clk, rst_n, i_clr, i_inc, o_cnt, o_sat, and implements the saturating and clear-priority rules above. The FSM and qualification counter stay in the top module.

## Test plan
- Reset with i_sig_sync=1, STABLE_CYCLES=4:
  - All outputs are 0 during reset.
  - After release, o_rise pulses exactly once, 4 cycles after the first sampled 1.
  - o_edge_cnt then reads 1.
- Glitch rejection, N=4:
  - Stimulus: high pulses of 1, 2, and 3 cycles from S_LOW.
  - Required: o_level stays 0, no pulses, o_edge_cnt unchanged.
  - Then a 4-cycle high: o_rise fires on the 4th sampled cycle.
- Square wave, N=4, high and low phases of 6 cycles each, 10 periods:
  - Exactly 10 rise and 10 fall pulses.
  - o_edge_cnt = 20.
  - o_level lags the input by 4 cycles.
- Saturation, CNT_WIDTH=3:
  - Stimulus: 9 accepted edges.
  - Required: o_edge_cnt holds at 7, with o_cnt_sat=1 from the 7th edge.
  - Then i_clr_cnt for one cycle: counter reads 0 and o_cnt_sat=0.
- Clear coinciding with an edge:
  - Stimulus: i_clr_cnt asserted in the same cycle as o_rise, with the counter at 5.
  - Required: counter reads 1 next cycle.
- N=1 and reset mid-qualification:
  - N=1: o_level follows i_sig_sync with one cycle of delay, and every toggle produces a pulse.
  - Reset mid-qualification (N=4): assert rst_n=0 when qcnt=2 while in S_LOW_CHK. No o_rise appears, and qualification restarts from 0 after release.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and limits for the destination-domain glitch filter.
package cdc_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_LOW_CHK,
        S_HIGH,
        S_HIGH_CHK
    } glitch_state_t;

    localparam int MAX_STABLE_CYCLES = 255;

endpackage

// File: rtl/cdc_glitch_filter_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes effect before the increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= i_inc ? CNT_ONE : '0;
        end else if (i_inc && (o_cnt != CNT_MAX)) begin
            o_cnt <= o_cnt + CNT_ONE;
        end
    end

    assign o_sat = (o_cnt == CNT_MAX);

endmodule

// File: rtl/cdc_glitch_filter.sv
// Accepts a synchronized level change only after it has held for STABLE_CYCLES samples;
// emits the filtered level, rise/fall pulses and a saturating accepted-edge count.
//
// state      | meaning
// S_LOW      | stable low, qcnt = 0
// S_LOW_CHK  | low, qualifying a high
// S_HIGH     | stable high, qcnt = 0
// S_HIGH_CHK | high, qualifying a low
module cdc_glitch_filter
    import cdc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sig_sync,
    input  logic                 i_clr_cnt,
    output logic                 o_level,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic [CNT_WIDTH-1:0] o_edge_cnt,
    output logic                 o_cnt_sat
);

    localparam int              QW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0]   Q_ONE  = QW'(1);
    localparam logic [QW-1:0]   Q_LAST = QW'(STABLE_CYCLES - 1);
    localparam logic            ONE_CYCLE = (STABLE_CYCLES == 1);

    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
            $error("cdc_glitch_filter: STABLE_CYCLES out of range 1..255");
        end
        if (CNT_WIDTH < 2) begin : g_bad_width
            $error("cdc_glitch_filter: CNT_WIDTH must be at least 2");
        end
    endgenerate

    glitch_state_t state, state_nxt;
    logic [QW-1:0] qcnt, qcnt_nxt;
    logic          rise_nxt, fall_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_LOW;
            qcnt   <= '0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            state  <= state_nxt;
            qcnt   <= qcnt_nxt;
            o_rise <= rise_nxt;
            o_fall <= fall_nxt;
        end
    end

    // Pulses are decided here and registered alongside the state so they line up with o_level.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            S_LOW: begin
                qcnt_nxt = '0;
                if (i_sig_sync) begin
                    if (ONE_CYCLE) begin
                        state_nxt = S_HIGH;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_LOW_CHK;
                        qcnt_nxt  = Q_ONE;
                    end
                end
            end
            S_LOW_CHK: begin
                if (!i_sig_sync) begin
                    state_nxt = S_LOW;
                    qcnt_nxt  = '0;
                end else if (qcnt == Q_LAST) begin
                    state_nxt = S_HIGH;
                    qcnt_nxt  = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    qcnt_nxt = qcnt + Q_ONE;
                end
            end
            S_HIGH: begin
                qcnt_nxt = '0;
                if (!i_sig_sync) begin
                    if (ONE_CYCLE) begin
                        state_nxt = S_LOW;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_HIGH_CHK;
                        qcnt_nxt  = Q_ONE;
                    end
                end
            end
            S_HIGH_CHK: begin
                if (i_sig_sync) begin
                    state_nxt = S_HIGH;
                    qcnt_nxt  = '0;
                end else if (qcnt == Q_LAST) begin
                    state_nxt = S_LOW;
                    qcnt_nxt  = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    qcnt_nxt = qcnt + Q_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                qcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        o_level = (state == S_HIGH) || (state == S_HIGH_CHK);
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_edge_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_clr_cnt),
        .i_inc (o_rise | o_fall),
        .o_cnt (o_edge_cnt),
        .o_sat (o_cnt_sat)
    );

endmodule

// File: tb/tb_cdc_glitch_filter.sv
// Directed bench for cdc_glitch_filter: N=4/8-bit, N=4/3-bit and N=1 instances on one clock.
module tb_cdc_glitch_filter;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    logic       rst_a, sig_a, clr_a, level_a, rise_a, fall_a, sat_a;
    logic [7:0] cnt_a;
    logic       rst_b, sig_b, clr_b, level_b, rise_b, fall_b, sat_b;
    logic [2:0] cnt_b;
    logic       rst_c, sig_c, clr_c, level_c, rise_c, fall_c, sat_c;
    logic [7:0] cnt_c;

    int       rises_a, falls_a;
    logic [3:0] hist;
    logic     prev_c;

    int   exp_sat_cnt [9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    int   exp_sat_flag[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic pat_c[10]       = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    cdc_glitch_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_a), .i_sig_sync(sig_a), .i_clr_cnt(clr_a),
        .o_level(level_a), .o_rise(rise_a), .o_fall(fall_a),
        .o_edge_cnt(cnt_a), .o_cnt_sat(sat_a)
    );

    cdc_glitch_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) u_b (
        .clk(clk), .rst_n(rst_b), .i_sig_sync(sig_b), .i_clr_cnt(clr_b),
        .o_level(level_b), .o_rise(rise_b), .o_fall(fall_b),
        .o_edge_cnt(cnt_b), .o_cnt_sat(sat_b)
    );

    cdc_glitch_filter #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) u_c (
        .clk(clk), .rst_n(rst_c), .i_sig_sync(sig_c), .i_clr_cnt(clr_c),
        .o_level(level_c), .o_rise(rise_c), .o_fall(fall_c),
        .o_edge_cnt(cnt_c), .o_cnt_sat(sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        rises_a += int'(rise_a);
        falls_a += int'(fall_a);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        sig_a = 1'b1; sig_b = 1'b0; sig_c = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        rises_a = 0; falls_a = 0;

        // reset held with input high
        repeat (3) tick();
        check("rst_level", 32'(level_a), 0);
        check("rst_rise",  32'(rise_a),  0);
        check("rst_fall",  32'(fall_a),  0);
        check("rst_cnt",   32'(cnt_a),   0);
        check("rst_sat",   32'(sat_a),   0);

        rst_a = 1'b1; rises_a = 0; falls_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel_rise_early", 32'(rise_a), 0);
            check("rel_level_early", 32'(level_a), 0);
        end
        tick();
        check("rel_rise", 32'(rise_a), 1);
        check("rel_level", 32'(level_a), 1);
        tick();
        check("rel_rise_clear", 32'(rise_a), 0);
        check("rel_cnt", 32'(cnt_a), 1);
        check("rel_rise_total", 32'(rises_a), 1);

        sig_a = 1'b0;
        repeat (4) tick();
        check("low_fall", 32'(fall_a), 1);
        check("low_level", 32'(level_a), 0);
        tick();
        check("low_cnt", 32'(cnt_a), 2);

        // glitches of 1, 2, 3 cycles
        rises_a = 0; falls_a = 0;
        for (int w = 1; w <= 3; w++) begin
            sig_a = 1'b1;
            repeat (w) begin
                tick();
                check("glitch_level_hi", 32'(level_a), 0);
            end
            sig_a = 1'b0;
            repeat (4) begin
                tick();
                check("glitch_level_lo", 32'(level_a), 0);
            end
        end
        check("glitch_rises", 32'(rises_a), 0);
        check("glitch_falls", 32'(falls_a), 0);
        check("glitch_cnt", 32'(cnt_a), 2);

        sig_a = 1'b1;
        repeat (3) tick();
        check("q4_rise_early", 32'(rise_a), 0);
        tick();
        check("q4_rise", 32'(rise_a), 1);
        tick();
        check("q4_cnt", 32'(cnt_a), 3);

        // clear alone, then square wave 6/6 for 10 periods
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("clr_cnt", 32'(cnt_a), 0);
        check("clr_level_kept", 32'(level_a), 1);
        rises_a = 0; falls_a = 0; hist = 4'b1111;
        for (int p = 0; p < 10; p++) begin
            for (int h = 0; h < 2; h++) begin
                sig_a = (h == 1);
                for (int k = 0; k < 6; k++) begin
                    tick();
                    hist = {hist[2:0], sig_a};
                    check("sq_lag", 32'(level_a), 32'(hist[3]));
                end
            end
        end
        tick();
        check("sq_rises", 32'(rises_a), 10);
        check("sq_falls", 32'(falls_a), 10);
        check("sq_cnt", 32'(cnt_a), 20);

        // reset while qualifying a high with qcnt=2
        sig_a = 1'b0;
        repeat (5) tick();
        sig_a = 1'b1;
        repeat (2) tick();
        check("midq_level", 32'(level_a), 0);
        rst_a = 1'b0;
        tick();
        check("midq_rst_level", 32'(level_a), 0);
        check("midq_rst_rise", 32'(rise_a), 0);
        check("midq_rst_cnt", 32'(cnt_a), 0);
        rst_a = 1'b1; rises_a = 0;
        repeat (3) tick();
        check("midq_rises_early", 32'(rises_a), 0);
        tick();
        check("midq_rise", 32'(rise_a), 1);
        check("midq_rises_total", 32'(rises_a), 1);

        // saturation on the 3-bit counter
        rst_b = 1'b1;
        for (int e = 0; e < 9; e++) begin
            sig_b = ~sig_b;
            repeat (5) tick();
            check("sat_cnt", 32'(cnt_b), 32'(exp_sat_cnt[e]));
            check("sat_flag", 32'(sat_b), 32'(exp_sat_flag[e]));
        end
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("sat_clr_cnt", 32'(cnt_b), 0);
        check("sat_clr_flag", 32'(sat_b), 0);
        check("sat_clr_level", 32'(level_b), 1);

        // clear coinciding with a rise pulse at count 5
        for (int e = 0; e < 5; e++) begin
            sig_b = ~sig_b;
            repeat (5) tick();
        end
        check("coin_pre_cnt", 32'(cnt_b), 5);
        sig_b = 1'b1;
        repeat (4) tick();
        check("coin_rise", 32'(rise_b), 1);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("coin_cnt", 32'(cnt_b), 1);
        check("coin_rise_clear", 32'(rise_b), 0);

        // N=1 follows input with one register of delay
        rst_c = 1'b1; prev_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sig_c = pat_c[i];
            tick();
            check("n1_level", 32'(level_c), 32'(pat_c[i]));
            check("n1_rise", 32'(rise_c), 32'(pat_c[i] & ~prev_c));
            check("n1_fall", 32'(fall_c), 32'(~pat_c[i] & prev_c));
            prev_c = pat_c[i];
        end
        tick();
        check("n1_cnt", 32'(cnt_c), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
